// File: rtl/m4_im_pkg.sv
// m4_im_pkg
//   Shared definitions for the M4 SRAM -> IM EEPROM coefficient readout:
//   controller state encoding, pad byte driven when no byte is presented,
//   and elaboration-time sizing helpers.
package m4_im_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  localparam logic [7:0] PAD_BYTE = 8'hFF;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Memory words needed to cover ncoef packed cw-bit coefficients.
  function automatic int nwords(input int ncoef, input int cw, input int mw);
    return (ncoef * cw + mw - 1) / mw;
  endfunction

endpackage

// File: rtl/m4_im_bitbuf.sv
// m4_im_bitbuf
//   LSB-first bit accumulator: MW-bit words are appended above the bits
//   already held, CW-bit coefficients are taken from the bottom.
// Ports
//   clk, rst      clock, synchronous active-low reset
//   i_clear       empty the buffer (start of a transfer)
//   i_push        append i_data at bit position o_fill
//   i_data        MW-bit memory word
//   i_pop         discard the bottom CW bits
//   o_data        bottom CW bits (current coefficient)
//   o_fill        number of valid bits held
module m4_im_bitbuf
  import m4_im_pkg::*;
#(
  parameter int MW = 32,
  parameter int CW = 13,
  localparam int BW = MW + CW - 1,
  localparam int FW = clog2(MW + CW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [MW-1:0] i_data,
  input  logic          i_pop,
  output logic [CW-1:0] o_data,
  output logic [FW-1:0] o_fill
);

  logic [BW-1:0] r_buf;
  logic [FW-1:0] r_fill;
  logic [BW-1:0] w_push_bits;

  // A push only happens with fewer than CW bits held, so the shifted word
  // always fits in MW+CW-1 bits and bits above r_fill are already zero.
  assign w_push_bits = {{(CW-1){1'b0}}, i_data} << r_fill;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (i_push) begin
      r_buf  <= r_buf | w_push_bits;
      r_fill <= r_fill + FW'(MW);
    end else if (i_pop) begin
      r_buf  <= r_buf >> CW;
      r_fill <= r_fill - FW'(CW);
    end
  end

  assign o_data = r_buf[CW-1:0];
  assign o_fill = r_fill;

endmodule

// File: rtl/m4_mem_rctrl_im_unpack.sv
// m4_mem_rctrl_im_unpack
//   Reads NCOEF packed CW-bit coefficients from SRAM starting at a runtime
//   base address and streams them as bytes (low byte, optional padded high
//   byte) over a valid/ready handshake toward the IM EEPROM writer.
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   i_start, i_abort         transfer request / cancel
//   i_hi_byte_en             emit high byte too (latched at start)
//   i_base_addr              first word address (latched at start)
//   o_mem_re, o_mem_addr     single-cycle read strobe and word address
//   i_mem_rvalid, i_mem_rdata  read return, variable latency
//   o_out_valid, i_out_ready, o_out_data, o_out_last  byte stream
//   o_busy, o_done           transfer in progress / completed pulse
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read strobe issued for the next word
// WAIT  | read outstanding
// EMIT  | bytes of buffered coefficients presented to the sink
// DONE  | one-cycle completion pulse
// DRAIN | aborted with a read outstanding; swallow the return
module m4_mem_rctrl_im_unpack
  import m4_im_pkg::*;
#(
  parameter int MW    = 32,
  parameter int CW    = 13,
  parameter int NCOEF = 32,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_hi_byte_en,
  input  logic [AW-1:0] i_base_addr,
  output logic          o_mem_re,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_rvalid,
  input  logic [MW-1:0] i_mem_rdata,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [7:0]    o_out_data,
  output logic          o_out_last,
  output logic          o_busy,
  output logic          o_done
);

  localparam int NWORDS = nwords(NCOEF, CW, MW);
  localparam int WIW    = clog2(NWORDS + 1);
  localparam int CCW    = clog2(NCOEF + 1);
  localparam int FW     = clog2(MW + CW);

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_base;
  logic            r_hi;
  logic [WIW-1:0]  r_word_idx;
  logic [CCW-1:0]  r_coef_cnt;
  logic            r_sel;
  logic            r_out_valid;

  logic [CW-1:0]   w_coef;
  logic [FW-1:0]   w_fill;
  logic [15:0]     w_coef16;
  logic            w_hs;
  logic            w_coef_end;
  logic            w_last_coef;
  logic            w_more;
  logic            w_push_enough;
  logic            w_clear;
  logic            w_push;
  logic            w_pop;

  assign w_hs          = r_out_valid & i_out_ready;
  assign w_coef_end    = w_hs & (~r_hi | r_sel);
  assign w_last_coef   = (r_coef_cnt == CCW'(NCOEF - 1));
  // Another coefficient remains buffered once the current one is popped.
  assign w_more        = (32'(w_fill) >= 32'(2 * CW));
  assign w_push_enough = (32'(w_fill) + 32'(MW) >= 32'(CW));

  assign w_clear = (r_state == IDLE)  & i_start & ~i_abort;
  assign w_push  = (r_state == WAIT)  & i_mem_rvalid & ~i_abort;
  assign w_pop   = (r_state == EMIT)  & w_coef_end & ~i_abort;

  m4_im_bitbuf #(
    .MW (MW),
    .CW (CW)
  ) u_bitbuf (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_data  (i_mem_rdata),
    .i_pop   (w_pop),
    .o_data  (w_coef),
    .o_fill  (w_fill)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (i_start) w_next = FETCH;
      FETCH: w_next = WAIT;
      WAIT:  if (i_mem_rvalid) w_next = w_push_enough ? EMIT : FETCH;
      EMIT: begin
        if (w_coef_end) begin
          if (w_last_coef) w_next = DONE;
          else if (w_more) w_next = EMIT;
          else             w_next = FETCH;
        end
      end
      DONE:  w_next = IDLE;
      DRAIN: if (i_mem_rvalid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // A return arriving together with abort needs no draining.
    if (i_abort) begin
      w_next = ((r_state == WAIT) && !i_mem_rvalid) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_base      <= '0;
      r_hi        <= 1'b0;
      r_word_idx  <= '0;
      r_coef_cnt  <= '0;
      r_sel       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Valid rises one cycle after entering EMIT and drops when leaving it.
      r_out_valid <= (r_state == EMIT) && (w_next == EMIT);
      if (w_clear) begin
        r_base     <= i_base_addr;
        r_hi       <= i_hi_byte_en;
        r_word_idx <= '0;
        r_coef_cnt <= '0;
        r_sel      <= 1'b0;
      end
      if (w_push) begin
        r_word_idx <= r_word_idx + WIW'(1);
      end
      if ((r_state == EMIT) && w_hs && !i_abort) begin
        r_sel <= r_hi & ~r_sel;
        if (w_coef_end) begin
          r_coef_cnt <= r_coef_cnt + CCW'(1);
        end
      end
    end
  end

  always_comb begin
    o_mem_re    = (r_state == FETCH);
    o_mem_addr  = o_mem_re ? (r_base + AW'(r_word_idx)) : '0;
    o_busy      = (r_state == FETCH) || (r_state == WAIT) ||
                  (r_state == EMIT)  || (r_state == DRAIN);
    o_done      = (r_state == DONE);
    o_out_valid = r_out_valid;
    // High byte carries c[CW-1:8] padded with ones above.
    w_coef16           = 16'hFFFF;
    w_coef16[CW-1:0]   = w_coef;
    if (!r_out_valid)  o_out_data = PAD_BYTE;
    else if (r_sel)    o_out_data = w_coef16[15:8];
    else               o_out_data = w_coef16[7:0];
    o_out_last  = r_out_valid & w_last_coef & (~r_hi | r_sel);
  end

endmodule
